tt_um_weight_loader: RTL and testbench

Parametrised, handshaked successor to the ternary weight loader: streams a full `MAX_IN_LEN x MAX_OUT_LEN` matrix of `WIDTH`-bit weights in as bit-plane beats into a shadow buffer. It commits the shadow to a stable active buffer in a single cycle, so downstream matrix-vector logic never sees a partially loaded matrix. It sits between the tile input pins and the ternary MAC array, and owns its own beat counter.

---
 rtl/tt_um_weight_loader.sv | 112 +++++++++++
 tb/tb_tt_um_weight_loader.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tt_um_weight_loader.sv
// Double-buffered weight loader: bit-plane beats fill a shadow matrix, which is
// copied to the active matrix in one cycle once the last beat has landed.
module tt_um_weight_loader #(
    parameter int unsigned MAX_IN_LEN  = 16,
    parameter int unsigned MAX_OUT_LEN = 8,
    parameter int unsigned WIDTH       = 2,
    parameter int unsigned BEATS       = MAX_OUT_LEN * WIDTH,
    parameter int unsigned COUNT_BITS  = $clog2(BEATS)
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      ena,
    input  logic                                      ui_start,
    input  logic                                      ui_valid,
    input  logic [MAX_IN_LEN-1:0]                     ui_input,
    output logic                                      uo_ready,
    output logic                                      uo_busy,
    output logic [COUNT_BITS-1:0]                     uo_count,
    output logic [WIDTH*MAX_IN_LEN*MAX_OUT_LEN-1:0]   uo_weights,
    output logic                                      uo_done
);

    localparam int unsigned NBITS = WIDTH * MAX_IN_LEN * MAX_OUT_LEN;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    localparam logic [COUNT_BITS-1:0] LAST_BEAT = COUNT_BITS'(BEATS - 1);

    // BEATS and COUNT_BITS are derived; overriding them breaks the mapping.
    if (BEATS != MAX_OUT_LEN * WIDTH) begin : g_bad_beats
        $error("BEATS must equal MAX_OUT_LEN*WIDTH");
    end

    logic [1:0]            state_q, state_d;
    logic [COUNT_BITS-1:0] count_q, count_d;
    logic [NBITS-1:0]      shadow_q, shadow_d;
    logic [NBITS-1:0]      active_q, active_d;
    logic                  done_q, done_d;

    // Next-state: sequencing, beat capture into shadow, and commit to active.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        shadow_d = shadow_q;
        active_d = active_q;
        done_d   = 1'b0;  // done is a single-cycle pulse, also cleared while disabled

        if (ena) begin
            case (state_q)
                ST_IDLE: begin
                    if (ui_start) begin
                        state_d = ST_LOAD;
                        count_d = '0;
                    end
                end
                ST_LOAD: begin
                    if (ui_start) begin
                        // Restart wins; a beat presented this cycle is dropped.
                        count_d = '0;
                    end else if (ui_valid) begin
                        for (int unsigned i = 0; i < MAX_IN_LEN; i++) begin
                            shadow_d[i*BEATS + 32'(count_q)] = ui_input[i];
                        end
                        if (count_q == LAST_BEAT) begin
                            count_d = '0;
                            state_d = ST_COMMIT;
                        end else begin
                            count_d = count_q + 1'b1;
                        end
                    end
                end
                ST_COMMIT: begin
                    active_d = shadow_q;
                    done_d   = 1'b1;
                    state_d  = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            shadow_q <= '0;
            active_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            done_q   <= done_d;
        end
    end

    // Outputs: ready is combinational on ena so a disabled cycle never accepts.
    always_comb begin
        uo_ready   = ena && (state_q == ST_LOAD);
        uo_busy    = (state_q != ST_IDLE);
        uo_count   = count_q;
        uo_weights = active_q;
        uo_done    = done_q;
    end

endmodule

// File: tb/tb_tt_um_weight_loader.sv
// Bench for tt_um_weight_loader: table of full loads checked against a bench
// model via a scoreboard, plus restart, reset, stretch and small-parameter cases.
module tb_tt_um_weight_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default-parameter DUT
    logic        rst_n, ena, ui_start, ui_valid;
    logic [15:0] ui_input;
    logic        uo_ready, uo_busy, uo_done;
    logic [3:0]  uo_count;
    logic [255:0] uo_weights;

    // Small-parameter DUT (4 rows, 3 cols, 2 bits -> 6 beats)
    logic        p_ena, p_start, p_valid;
    logic [3:0]  p_input;
    logic        p_ready, p_busy, p_done;
    logic [2:0]  p_count;
    logic [23:0] p_weights;

    tt_um_weight_loader dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_start(ui_start), .ui_valid(ui_valid),
        .ui_input(ui_input), .uo_ready(uo_ready), .uo_busy(uo_busy), .uo_count(uo_count),
        .uo_weights(uo_weights), .uo_done(uo_done)
    );

    tt_um_weight_loader #(.MAX_IN_LEN(4), .MAX_OUT_LEN(3), .WIDTH(2)) dut_p (
        .clk(clk), .rst_n(rst_n), .ena(p_ena), .ui_start(p_start), .ui_valid(p_valid),
        .ui_input(p_input), .uo_ready(p_ready), .uo_busy(p_busy), .uo_count(p_count),
        .uo_weights(p_weights), .uo_done(p_done)
    );

    int checks = 0;
    int errors = 0;
    logic [255:0] committed;
    logic [255:0] exp_q[$];

    typedef struct {
        logic [15:0] pat;
        int          step;
        bit          gaps;
        bit          skip_start;
        bit          chain;
        int          exp_ones;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Beat k is pat rotated left by step*k.
    function automatic logic [15:0] beat_of(input logic [15:0] pat, input int step, input int k);
        logic [31:0] d;
        int s;
        s = (step * k) % 16;
        d = {pat, pat} << s;
        return d[31:16];
    endfunction

    function automatic logic [255:0] model(input logic [15:0] pat, input int step);
        logic [255:0] r;
        logic [15:0] b;
        r = '0;
        for (int k = 0; k < 16; k++) begin
            b = beat_of(pat, step, k);
            for (int i = 0; i < 16; i++) r[i*16+k] = b[i];
        end
        return r;
    endfunction

    task automatic start_load();
        ena = 1'b1; ui_start = 1'b1; ui_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        ui_start = 1'b0;
        #1;
        chk("start_ready", 256'(uo_ready), 256'(1));
        chk("start_busy", 256'(uo_busy), 256'(1));
        chk("start_count", 256'(uo_count), 256'(0));
    endtask

    task automatic drive_beats(input int n, input logic [15:0] d);
        for (int j = 0; j < n; j++) begin
            ena = 1'b1; ui_valid = 1'b1; ui_input = d;
            @(posedge clk); @(negedge clk);
        end
        ui_valid = 1'b0;
    endtask

    // Full load; bench decides acceptance (ena & valid in LOAD) and tracks the count.
    task automatic run_load(input logic [15:0] pat, input int step, input bit gaps,
                            input bit skip_start, input bit chain);
        int k;
        int cyc;
        bit ena_v;
        bit valid_v;
        logic [255:0] e;
        if (!skip_start) start_load();
        k = 0; cyc = 0;
        while (k < 16 && cyc < 200) begin
            ena_v   = !(gaps && cyc >= 4 && cyc < 7);
            valid_v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            ena = ena_v; ui_valid = valid_v; ui_input = beat_of(pat, step, k);
            #1;
            chk("load_count", 256'(uo_count), 256'(k));
            chk("load_ready", 256'(uo_ready), 256'(ena_v));
            chk("load_busy", 256'(uo_busy), 256'(1));
            chk("load_stable", uo_weights, committed);
            @(posedge clk);
            if (ena_v && valid_v) k++;
            cyc++;
            @(negedge clk);
        end
        if (k < 16) chk("load_timeout", 256'(k), 256'(16));
        ena = 1'b1; ui_valid = 1'b0;
        #1;
        chk("commit_busy", 256'(uo_busy), 256'(1));
        chk("commit_ready", 256'(uo_ready), 256'(0));
        chk("commit_done", 256'(uo_done), 256'(0));
        chk("commit_stable", uo_weights, committed);
        if (chain) ui_start = 1'b1;  // must be ignored in COMMIT
        exp_q.push_back(model(pat, step));
        @(posedge clk); @(negedge clk);
        #1;
        chk("done_high", 256'(uo_done), 256'(1));
        chk("done_busy", 256'(uo_busy), 256'(0));
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("weights", uo_weights, e);
            committed = e;
        end
        @(posedge clk); @(negedge clk);
        ui_start = 1'b0;
        #1;
        chk("done_low", 256'(uo_done), 256'(0));
        if (chain) begin
            chk("chain_busy", 256'(uo_busy), 256'(1));
            chk("chain_count", 256'(uo_count), 256'(0));
            chk("chain_ready", 256'(uo_ready), 256'(1));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] diag;
        logic [23:0]  pw;
        logic [3:0]   pd;
        logic [255:0] pe;

        vecs[0] = '{pat: 16'h0001, step: 1, gaps: 1'b0, skip_start: 1'b0, chain: 1'b0, exp_ones: 16};
        vecs[1] = '{pat: 16'h0000, step: 0, gaps: 1'b0, skip_start: 1'b0, chain: 1'b0, exp_ones: 0};
        vecs[2] = '{pat: 16'hFFFF, step: 0, gaps: 1'b1, skip_start: 1'b0, chain: 1'b0, exp_ones: 256};
        vecs[3] = '{pat: 16'hA5A5, step: 0, gaps: 1'b0, skip_start: 1'b0, chain: 1'b1, exp_ones: 128};
        vecs[4] = '{pat: 16'h0003, step: 1, gaps: 1'b1, skip_start: 1'b1, chain: 1'b0, exp_ones: 32};

        rst_n = 1'b0; ena = 1'b0; ui_start = 1'b0; ui_valid = 1'b0; ui_input = '0;
        p_ena = 1'b1; p_start = 1'b0; p_valid = 1'b0; p_input = '0;
        committed = '0;
        #12;
        chk("rst_weights", uo_weights, 256'(0));
        chk("rst_busy", 256'(uo_busy), 256'(0));
        chk("rst_ready", 256'(uo_ready), 256'(0));
        chk("rst_count", 256'(uo_count), 256'(0));
        chk("rst_done", 256'(uo_done), 256'(0));
        @(negedge clk);
        rst_n = 1'b1;
        ena = 1'b1;
        @(negedge clk);

        // Table of full loads
        for (int v = 0; v < 5; v++) begin
            run_load(vecs[v].pat, vecs[v].step, vecs[v].gaps, vecs[v].skip_start, vecs[v].chain);
            chk("ones", 256'($countones(uo_weights)), 256'(vecs[v].exp_ones));
            if (v == 0) begin
                diag = '0;
                for (int i = 0; i < 16; i++) diag[i*16+i] = 1'b1;
                chk("diag", uo_weights, diag);
            end
        end

        // Restart with a simultaneous beat: count clears, beat dropped
        start_load();
        drive_beats(7, 16'hFFFF);
        #1;
        chk("pre_restart_count", 256'(uo_count), 256'(7));
        ui_start = 1'b1; ui_valid = 1'b1; ui_input = 16'hFFFF;
        @(posedge clk); @(negedge clk);
        ui_start = 1'b0; ui_valid = 1'b0;
        #1;
        chk("restart_count", 256'(uo_count), 256'(0));
        chk("restart_busy", 256'(uo_busy), 256'(1));
        run_load(16'h0000, 0, 1'b0, 1'b1, 1'b0);
        chk("restart_zero", uo_weights, 256'(0));

        // Reset mid-load discards everything, including active
        run_load(16'h5A5A, 0, 1'b0, 1'b0, 1'b0);
        start_load();
        drive_beats(5, 16'h1234);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_weights", uo_weights, 256'(0));
        chk("midrst_busy", 256'(uo_busy), 256'(0));
        chk("midrst_count", 256'(uo_count), 256'(0));
        chk("midrst_ready", 256'(uo_ready), 256'(0));
        chk("midrst_done", 256'(uo_done), 256'(0));
        @(negedge clk);
        rst_n = 1'b1;
        committed = '0;
        @(posedge clk); @(negedge clk);
        #1;
        chk("postrst_busy", 256'(uo_busy), 256'(0));
        chk("postrst_count", 256'(uo_count), 256'(0));

        // Small parameter set: 6 beats, counter wraps 5 -> 0, COMMIT stretched by ena
        p_start = 1'b1;
        @(posedge clk); @(negedge clk);
        p_start = 1'b0;
        pw = '0;
        for (int k = 0; k < 6; k++) begin
            pd = 4'((k * 5 + 3) % 16);
            for (int i = 0; i < 4; i++) pw[i*6+k] = pd[i];
            p_valid = 1'b1; p_input = pd;
            #1;
            chk("p_count", 256'(p_count), 256'(k));
            @(posedge clk); @(negedge clk);
        end
        p_valid = 1'b0;
        exp_q.push_back(256'(pw));
        p_ena = 1'b0;
        #1;
        chk("p_wrap", 256'(p_count), 256'(0));
        for (int j = 0; j < 2; j++) begin
            @(posedge clk); @(negedge clk);
            #1;
            chk("p_stretch_busy", 256'(p_busy), 256'(1));
            chk("p_stretch_done", 256'(p_done), 256'(0));
            chk("p_stretch_w", 256'(p_weights), 256'(0));
        end
        p_ena = 1'b1;
        @(posedge clk); @(negedge clk);
        #1;
        chk("p_done", 256'(p_done), 256'(1));
        chk("p_busy", 256'(p_busy), 256'(0));
        if (exp_q.size() > 0) begin
            pe = exp_q.pop_front();
            chk("p_weights", 256'(p_weights), pe);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
